// File: rtl/bcd_display_formatter.sv
// Binary to six-digit packed-BCD formatter for led_display_driver.
// Iterative double-dabble with leading-zero blanking, decimal-point forcing and overflow saturation.
module bcd_display_formatter #(
    parameter int BIN_WIDTH          = 20,
    parameter bit LEADING_ZERO_BLANK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] value,
    input  logic [5:0]           dp_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [23:0]          data,
    output logic [5:0]           digit_enable_mask,
    output logic [5:0]           decimal_point_enable_mask
);

    // state  | meaning
    // IDLE   | waiting for start; outputs hold the last result
    // SHIFT  | one add-3 / shift step per edge, count runs down from BIN_WIDTH
    // FINISH | register formatted result and pulse done
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    state_t               state;
    state_t               state_next;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [31:0]          acc;
    logic [31:0]          acc_adj;
    logic [CNT_W-1:0]     count;
    logic [5:0]           dp_cap;
    logic                 accept;
    logic                 count_tc;
    logic                 ovf_calc;
    logic [5:0]           mask_calc;
    logic                 seen_nonzero;

    assign accept   = (state == IDLE) && start;
    assign count_tc = (count == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count_tc) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == FINISH);
    end

    // Add-3 correction on every nibble before the shift step.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr <= '0;
            acc    <= '0;
            count  <= '0;
            dp_cap <= '0;
        end else if (accept) begin
            bin_sr <= value;
            acc    <= '0;
            count  <= CNT_W'(BIN_WIDTH);
            dp_cap <= dp_mask;
        end else if (state == SHIFT) begin
            acc    <= {acc_adj[30:0], bin_sr[BIN_WIDTH-1]};
            bin_sr <= bin_sr << 1;
            count  <= count - CNT_W'(1);
        end
    end

    assign ovf_calc = |acc[31:24];

    // A digit stays lit if it or any more significant digit is nonzero or carries a decimal point.
    always_comb begin
        mask_calc    = 6'b000000;
        seen_nonzero = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            seen_nonzero = seen_nonzero || (acc[4*i +: 4] != 4'd0) || dp_cap[i];
            mask_calc[i] = seen_nonzero;
        end
        mask_calc[0] = 1'b1;
        if (ovf_calc || !LEADING_ZERO_BLANK) begin
            mask_calc = 6'b111111;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done                      <= 1'b0;
            overflow                  <= 1'b0;
            data                      <= 24'h000000;
            digit_enable_mask         <= 6'b000001;
            decimal_point_enable_mask <= 6'b000000;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) begin
                overflow                  <= ovf_calc;
                data                      <= ovf_calc ? 24'h999999 : acc[23:0];
                digit_enable_mask         <= mask_calc;
                decimal_point_enable_mask <= dp_cap;
            end
        end
    end

endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
Converts an unsigned binary value into the six-digit packed-BCD word consumed directly by led_display_driver. Drives its data, digit_enable_mask and decimal_point_enable_mask inputs. Uses an iterative double-dabble (shift-and-add-3) engine with a start/busy/done handshake. Adds optional leading-zero blanking, decimal-point-aware digit forcing and overflow saturation.

Parameters:
BIN_WIDTH, 20, width of binary input; legal range 4..24.
LEADING_ZERO_BLANK, 1, 1 = blank leading zero digits; 0 = all six digits always enabled.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  conversion request; sampled on rising clk.
value  input  BIN_WIDTH  unsigned binary operand; captured when start is accepted.
dp_mask  input  6  decimal-point request per digit; captured with value.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; outputs below updated in the same cycle.
overflow  output  1  high if last captured value > 999999; held until next done.
data  output  24  packed BCD; digit i = data[4i+3:4i], digit 0 least significant.
digit_enable_mask  output  6  bit i enables digit i.
decimal_point_enable_mask  output  6  registered copy of captured dp_mask.

Behaviour:
- Reset values: busy=0, done=0, overflow=0, data=24'h000000, digit_enable_mask=6'b000001, decimal_point_enable_mask=6'b000000. The FSM enters IDLE.
- FSM states:
  - IDLE: start=1 at an edge captures value and dp_mask, clears the BCD accumulator, loads shift count=BIN_WIDTH, goes to SHIFT, and sets busy=1.
  - SHIFT: each edge adds 3 to every accumulator nibble >=5, then shifts left one bit, taking in the binary MSB. The count decrements. After BIN_WIDTH shift edges the FSM goes to FINISH.
  - FINISH: one edge registers outputs, sets done=1, sets busy=0, and returns to IDLE.
- Latency: start accepted at edge k gives done high for the cycle following edge k+BIN_WIDTH+1. For the default of 20 this is 21 edges.
- Internal accumulator: 8 BCD digits (32 bits). This is enough for BIN_WIDTH up to 24.
- Overflow: if any accumulator digit above digit 5 is nonzero, then data=24'h999999, overflow=1 and digit_enable_mask=6'b111111. dp mask is still passed through unchanged.
- Blanking with LEADING_ZERO_BLANK=1: bit i is set if any digit j>=i is nonzero, or if dp_mask has any bit j>=i set. Bit 0 is always set, so a value of 0 displays "0".
- Blanking with LEADING_ZERO_BLANK=0: mask is always 6'b111111.
- start while busy: ignored, with no effect on the conversion in flight.
- start during the done cycle: FSM is in IDLE that cycle, so start is accepted. busy rises at the next edge and done falls.
- done: high exactly one cycle per conversion, never while busy=1.
- Output stability: outputs change only at the FINISH edge or on reset, so the display never shows partial results.
- Reset mid-conversion: asynchronous abort; all outputs return to reset values immediately. No done is issued for the aborted request.

Test Plan:
- Reset released, value=123456, dp_mask=0, start pulse -> busy high for 21 cycles, then done pulse with data=24'h123456, digit_enable_mask=6'b111111, overflow=0.
- value=42, start -> data=24'h000042, digit_enable_mask=6'b000011; value=0 -> data=24'h000000, mask=6'b000001.
- value=5, dp_mask=6'b000100 -> data=24'h000005, digit_enable_mask=6'b000111, decimal_point_enable_mask=6'b000100.
- value=1000000 (and value=20'hFFFFF) -> data=24'h999999, overflow=1, mask=6'b111111. A following value=7 -> overflow=0, data=24'h000007.
- start re-pulsed with value=999 mid-conversion of 654321 -> ignored, done shows 24'h654321. start held high across the done cycle -> second conversion begins immediately with the value present at the done edge.
- reset asserted at cycle 10 of a conversion -> outputs return to reset values asynchronously, busy=0, no done pulse. A new start after release converts correctly.
